regfile: RTL and testbench
==========================

Name: regfile

Overview:
- General-purpose register file for the MIPS core: 32 x 32-bit registers, r0 hardwired to zero.
- Serves the decode stage's two read ports (enable, address, data) and accepts one write per cycle from write-back.
- Includes a sequential dump port that streams all registers out over a valid/ready handshake, for bench checking and debug.

Parameters:
- DATA_W, 32, register data width (RegDataBus).
- ADDR_W, 5, register address width (RegAddrBus).
- REG_NUM, 32, number of registers; equals 2**ADDR_W.

Ports:
- clk  in  1  core clock, all state rising-edge.
- rst  in  1  asynchronous, active-high reset.
- we  in  1  write enable from write-back.
- waddr  in  ADDR_W  write address.
- wdata  in  DATA_W  write data.
- re1  in  1  read enable, port 1.
- raddr1  in  ADDR_W  read address, port 1.
- rdata1  out  DATA_W  read data, port 1 (combinational).
- re2  in  1  read enable, port 2.
- raddr2  in  ADDR_W  read address, port 2.
- rdata2  out  DATA_W  read data, port 2 (combinational).
- dump_start  in  1  request a full register dump; sampled only in IDLE.
- dump_valid  out  1  dump_data/dump_idx hold a valid register.
- dump_ready  in  1  consumer accepts the current dump beat.
- dump_idx  out  ADDR_W  index of the register on dump_data.
- dump_data  out  DATA_W  registered register value.
- dump_busy  out  1  high from the dump_start acceptance edge until the end of the last beat.
- dump_done  out  1  one-cycle pulse after beat 31 is accepted.

Behaviour:
- Reset: clk and rst are one clock and an asynchronous active-high reset. While rst=1:
  - all registers clear to 0, and rdata1=rdata2=0;
  - FSM goes to IDLE; dump_valid, dump_busy and dump_done are 0; dump_idx and dump_data are 0.
  - Reset mid-dump aborts the dump; no dump_done is issued.
- Write:
  - On the rising clk edge with we=1 and waddr!=0, reg[waddr] <= wdata.
  - A write to waddr=0 is ignored; r0 always reads 0.
- Read, combinational, per port n:
  - re_n=0 -> rdata_n=0.
  - raddr_n=0 -> 0.
  - else if we=1 and waddr==raddr_n -> wdata (write-to-read bypass, same cycle).
  - else reg[raddr_n].
  - Both ports may read the same address; both get identical data.
- Dump FSM, states IDLE, XFER, DONE:
  - IDLE: if dump_start=1, go to XFER, set dump_idx=0 and capture dump_data from reg 0 (value 0). dump_valid and dump_busy go high the next cycle.
  - XFER: dump_data and dump_idx stay stable while dump_valid=1 and dump_ready=0.
  - XFER, on dump_valid and dump_ready with dump_idx<31: dump_idx increments and dump_data captures reg[dump_idx+1]. If the same edge writes that index (we=1, waddr==dump_idx+1), dump_data captures wdata instead. A beat can be accepted every cycle, so the minimum dump is 32 cycles.
  - XFER, on handshake with dump_idx=31: go to DONE; dump_valid drops.
  - DONE: dump_done=1 for one cycle, dump_busy=0, then return to IDLE.
  - A write to a register already streamed or currently presented does not alter the presented beat.
  - dump_start outside IDLE is ignored.
  - dump_ready while dump_valid=0 has no effect.
- Normal reads and writes are fully independent of the dump FSM.

Test Plan:
- Assert rst async mid-cycle after writing r5=0x12345678 -> rdata1 of r5 reads 0 immediately; a dump shows all 32 registers as 0.
- Write r3=0xDEADBEEF; next cycle re1=1, raddr1=3 -> rdata1=0xDEADBEEF. Then set re1=0 -> rdata1=0.
- Same cycle: we=1, waddr=7, wdata=0xA5A5A5A5, re2=1, raddr2=7 -> rdata2=0xA5A5A5A5 (bypass). Also write r0=0xFFFFFFFF -> r0 reads 0 on both ports.
- Load r1..r31 with value i*0x01010101; pulse dump_start; hold dump_ready=1 -> 32 beats on consecutive cycles, idx 0..31, data matching. dump_done pulses once, one cycle after beat 31.
- During a dump with dump_ready toggling 1/0, write r10=0x55 while idx=10 is presented and stalled -> dump_data stays at the old r10 value until accepted. A later read of r10 returns 0x55.
- Assert rst at dump_idx=15 -> dump_valid=0 and FSM in IDLE; no dump_done. A new dump_start restarts from idx 0.

Source files
------------

// File: rtl/regfile_if.sv
// -----------------------------------------------------------------------------
// regfile_if : bundle of all non-clock signals of the MIPS register file.
//
//   Write port   : we, waddr, wdata                (write-back -> regfile)
//   Read port 1  : re1, raddr1 -> rdata1           (decode <-> regfile)
//   Read port 2  : re2, raddr2 -> rdata2           (decode <-> regfile)
//   Dump stream  : dump_start, dump_ready          (consumer -> regfile)
//                  dump_valid, dump_idx, dump_data,
//                  dump_busy, dump_done            (regfile -> consumer)
//   Debug        : dump_state (encoding of the dump FSM state)
//
// Modports: master = the core/bench driving the register file,
//           slave  = the register file itself.
// -----------------------------------------------------------------------------
interface regfile_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;

  logic              re1;
  logic [ADDR_W-1:0] raddr1;
  logic [DATA_W-1:0] rdata1;

  logic              re2;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata2;

  logic              dump_start;
  logic              dump_valid;
  logic              dump_ready;
  logic [ADDR_W-1:0] dump_idx;
  logic [DATA_W-1:0] dump_data;
  logic              dump_busy;
  logic              dump_done;
  logic [1:0]        dump_state;

  modport master (
    output we, waddr, wdata,
    output re1, raddr1, re2, raddr2,
    output dump_start, dump_ready,
    input  rdata1, rdata2,
    input  dump_valid, dump_idx, dump_data, dump_busy, dump_done, dump_state
  );

  modport slave (
    input  we, waddr, wdata,
    input  re1, raddr1, re2, raddr2,
    input  dump_start, dump_ready,
    output rdata1, rdata2,
    output dump_valid, dump_idx, dump_data, dump_busy, dump_done, dump_state
  );
endinterface

// File: rtl/regfile.sv
// -----------------------------------------------------------------------------
// regfile : 32 x 32-bit general-purpose register file for the MIPS core.
//
// Ports:
//   clk  - core clock, all state on the rising edge
//   rst  - asynchronous, active-high reset (clears all registers and the FSM)
//   bus  - regfile_if.slave:
//          one write port (we/waddr/wdata), two combinational read ports
//          (re_n/raddr_n -> rdata_n) with same-cycle write-to-read bypass,
//          and a sequential dump stream (dump_*) plus dump_state debug.
//
// r0 is hardwired to zero: writes to address 0 are dropped and reads of
// address 0 return 0 regardless of a pending write.
//
// Dump handshake: a beat transfers on a rising edge where dump_valid=1 and
// dump_ready=1. While dump_valid=1 and dump_ready=0, dump_idx and dump_data
// hold steady. dump_ready is ignored while dump_valid=0. dump_data is a
// registered snapshot, so later writes never disturb a presented beat.
// -----------------------------------------------------------------------------
module regfile #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int REG_NUM = 32
) (
  input  logic      clk,
  input  logic      rst,
  regfile_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(REG_NUM - 1);

  logic [DATA_W-1:0] r_regs [REG_NUM];

  state_t            r_state;
  logic              r_dump_valid;
  logic              r_dump_busy;
  logic              r_dump_done;
  logic [ADDR_W-1:0] r_dump_idx;
  logic [DATA_W-1:0] r_dump_data;

  logic [DATA_W-1:0] w_rdata1;
  logic [DATA_W-1:0] w_rdata2;
  logic [ADDR_W-1:0] w_next_idx;
  logic [DATA_W-1:0] w_next_data;
  logic              w_wr_en;

  // Address 0 is never stored, so r_regs[0] stays at its reset value of 0.
  assign w_wr_en = bus.we && (bus.waddr != '0);

  // ---------------------------------------------------------------------------
  // Register array
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_regs[bus.waddr] <= bus.wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Combinational read ports with write-to-read bypass
  // ---------------------------------------------------------------------------
  always_comb begin
    w_rdata1 = '0;
    if (!rst && bus.re1 && (bus.raddr1 != '0)) begin
      if (bus.we && (bus.waddr == bus.raddr1)) begin
        w_rdata1 = bus.wdata;
      end else begin
        w_rdata1 = r_regs[bus.raddr1];
      end
    end
  end

  always_comb begin
    w_rdata2 = '0;
    if (!rst && bus.re2 && (bus.raddr2 != '0)) begin
      if (bus.we && (bus.waddr == bus.raddr2)) begin
        w_rdata2 = bus.wdata;
      end else begin
        w_rdata2 = r_regs[bus.raddr2];
      end
    end
  end

  assign bus.rdata1 = w_rdata1;
  assign bus.rdata2 = w_rdata2;

  // ---------------------------------------------------------------------------
  // Dump FSM
  // ---------------------------------------------------------------------------
  // The next beat is loaded on the same edge a write may land on it; take the
  // incoming write data so the snapshot reflects the register after that edge.
  // w_next_idx is never 0 when used (only for idx < LAST_IDX), so w_wr_en's
  // r0 filter is not needed here beyond the address match.
  assign w_next_idx  = r_dump_idx + ADDR_W'(1);
  assign w_next_data = (bus.we && (bus.waddr == w_next_idx)) ? bus.wdata
                                                             : r_regs[w_next_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_dump_valid <= 1'b0;
      r_dump_busy  <= 1'b0;
      r_dump_done  <= 1'b0;
      r_dump_idx   <= '0;
      r_dump_data  <= '0;
    end else begin
      r_dump_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.dump_start) begin
            r_state      <= XFER;
            r_dump_valid <= 1'b1;
            r_dump_busy  <= 1'b1;
            r_dump_idx   <= '0;
            r_dump_data  <= '0;  // r0 is always zero
          end
        end
        XFER: begin
          if (r_dump_valid && bus.dump_ready) begin
            if (r_dump_idx == LAST_IDX) begin
              r_state      <= DONE;
              r_dump_valid <= 1'b0;
              r_dump_busy  <= 1'b0;
              r_dump_done  <= 1'b1;
            end else begin
              r_dump_idx  <= w_next_idx;
              r_dump_data <= w_next_data;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.dump_valid = r_dump_valid;
  assign bus.dump_busy  = r_dump_busy;
  assign bus.dump_done  = r_dump_done;
  assign bus.dump_idx   = r_dump_idx;
  assign bus.dump_data  = r_dump_data;
  assign bus.dump_state = r_state;

endmodule

// File: tb/tb_regfile.sv
// -----------------------------------------------------------------------------
// tb_regfile : directed self-checking bench for regfile.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
// Dump beats are predicted from a bench-side register model and queued in
// exp_q when the dump is requested; each accepted beat pops one entry.
// -----------------------------------------------------------------------------
module tb_regfile;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int REG_NUM = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  regfile_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_NUM(REG_NUM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_W-1:0]        model [REG_NUM];
  logic [ADDR_W+DATA_W-1:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < REG_NUM; i++) model[i] = '0;
  endtask

  // One write, issued at a falling edge, committed on the following rising edge.
  task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.we = 1'b1; bus.waddr = a; bus.wdata = d;
    @(negedge clk);
    bus.we = 1'b0;
    if (a != '0) model[a] = d;
  endtask

  task automatic rd1(input string tag, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp);
    bus.re1 = 1'b1; bus.raddr1 = a;
    #1 check(tag, bus.rdata1, exp);
  endtask

  task automatic rd2(input string tag, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp);
    bus.re2 = 1'b1; bus.raddr2 = a;
    #1 check(tag, bus.rdata2, exp);
  endtask

  // Full dump. toggle: dump_ready alternates 0/1 instead of staying high.
  // stall_wr_idx: write 0x55 to that register while its beat is stalled.
  // byp_idx: write 0xCAFEF00D to that register on the edge its beat is loaded.
  // abort_idx: assert reset mid-cycle once that index is presented.
  task automatic do_dump(input bit toggle, input int stall_wr_idx,
                         input int byp_idx, input int abort_idx);
    int beats = 0;
    int cyc = 0;
    int dones = 0;
    bit stall_done = 1'b0;
    logic [ADDR_W+DATA_W-1:0] e;
    exp_q.delete();
    for (int i = 0; i < REG_NUM; i++) exp_q.push_back({ADDR_W'(i), model[i]});
    bus.dump_start = 1'b1;
    @(negedge clk);
    bus.dump_start = 1'b0;
    check("dump_valid_after_start", bus.dump_valid, 1);
    check("dump_busy_after_start", bus.dump_busy, 1);
    while (beats < REG_NUM && cyc < 400) begin
      bus.we = 1'b0;
      bus.dump_start = 1'b0;
      bus.dump_ready = toggle ? cyc[0] : 1'b1;
      if (abort_idx >= 0 && bus.dump_idx == ADDR_W'(abort_idx)) begin
        #2 rst = 1'b1;
        #1;
        check("abort_valid", bus.dump_valid, 0);
        check("abort_busy", bus.dump_busy, 0);
        check("abort_done", bus.dump_done, 0);
        check("abort_state", bus.dump_state, ST_IDLE);
        check("abort_idx", bus.dump_idx, 0);
        check("abort_data", bus.dump_data, 0);
        exp_q.delete();
        clear_model();
        @(negedge clk);
        rst = 1'b0;
        bus.dump_ready = 1'b0;
        #1 check("abort_no_done_after", bus.dump_done, 0);
        @(negedge clk);
        return;
      end
      // A dump request while busy must be ignored.
      if (bus.dump_idx == ADDR_W'(5)) bus.dump_start = 1'b1;
      if (stall_wr_idx >= 0 && !stall_done && bus.dump_valid && !bus.dump_ready &&
          bus.dump_idx == ADDR_W'(stall_wr_idx)) begin
        bus.we = 1'b1; bus.waddr = ADDR_W'(stall_wr_idx); bus.wdata = 32'h0000_0055;
        model[stall_wr_idx] = 32'h0000_0055;
        stall_done = 1'b1;
      end
      if (byp_idx > 0 && bus.dump_valid && bus.dump_ready &&
          bus.dump_idx == ADDR_W'(byp_idx - 1)) begin
        bus.we = 1'b1; bus.waddr = ADDR_W'(byp_idx); bus.wdata = 32'hCAFE_F00D;
        model[byp_idx] = 32'hCAFE_F00D;
        exp_q[1] = {ADDR_W'(byp_idx), 32'hCAFE_F00D};
      end
      #1;
      if (bus.dump_done) dones++;
      if (bus.dump_valid && bus.dump_ready) begin
        e = exp_q.pop_front();
        check("dump_idx", 32'(bus.dump_idx), 32'(e[ADDR_W+DATA_W-1:DATA_W]));
        check("dump_data", bus.dump_data, e[DATA_W-1:0]);
        beats++;
      end
      @(negedge clk);
      cyc++;
    end
    bus.dump_ready = 1'b0; bus.we = 1'b0; bus.dump_start = 1'b0;
    check("dump_beats", beats, REG_NUM);
    if (!toggle) check("dump_cycles", cyc, REG_NUM);
    check("dump_done_early", dones, 0);
    #1;
    check("dump_done_pulse", bus.dump_done, 1);
    check("dump_busy_in_done", bus.dump_busy, 0);
    check("dump_valid_in_done", bus.dump_valid, 0);
    check("dump_state_done", bus.dump_state, ST_DONE);
    @(negedge clk);
    #1;
    check("dump_done_one_cycle", bus.dump_done, 0);
    check("dump_state_idle", bus.dump_state, ST_IDLE);
    check("dump_valid_idle", bus.dump_valid, 0);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    bus.we = 1'b0; bus.waddr = '0; bus.wdata = '0;
    bus.re1 = 1'b0; bus.raddr1 = '0; bus.re2 = 1'b0; bus.raddr2 = '0;
    bus.dump_start = 1'b0; bus.dump_ready = 1'b0;
    clear_model();
    @(negedge clk);
    @(negedge clk);

    // Reset state
    check("rst_valid", bus.dump_valid, 0);
    check("rst_busy", bus.dump_busy, 0);
    check("rst_done", bus.dump_done, 0);
    check("rst_idx", bus.dump_idx, 0);
    check("rst_data", bus.dump_data, 0);
    check("rst_state", bus.dump_state, ST_IDLE);
    rd1("rst_rdata1", 5'd5, 32'h0);
    rd2("rst_rdata2", 5'd9, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Async reset clears a written register immediately
    wr(5'd5, 32'h1234_5678);
    rd1("r5_before_rst", 5'd5, 32'h1234_5678);
    #2 rst = 1'b1;
    #1 check("r5_async_rst", bus.rdata1, 32'h0);
    clear_model();
    @(negedge clk);
    rst = 1'b0;
    bus.re1 = 1'b0;
    @(negedge clk);
    do_dump(1'b0, -1, -1, -1);

    // Plain write then read, and read-enable gating
    wr(5'd3, 32'hDEAD_BEEF);
    rd1("r3_read", 5'd3, 32'hDEAD_BEEF);
    bus.re1 = 1'b0;
    #1 check("r3_re1_low", bus.rdata1, 32'h0);
    @(negedge clk);

    // Same-cycle bypass on both ports
    bus.we = 1'b1; bus.waddr = 5'd7; bus.wdata = 32'hA5A5_A5A5;
    rd2("bypass_p2", 5'd7, 32'hA5A5_A5A5);
    rd1("bypass_p1", 5'd7, 32'hA5A5_A5A5);
    @(negedge clk);
    bus.we = 1'b0;
    model[7] = 32'hA5A5_A5A5;
    rd1("r7_after_write", 5'd7, 32'hA5A5_A5A5);

    // r0 stays zero, including during a write to it
    bus.we = 1'b1; bus.waddr = 5'd0; bus.wdata = 32'hFFFF_FFFF;
    rd1("r0_bypass_p1", 5'd0, 32'h0);
    rd2("r0_bypass_p2", 5'd0, 32'h0);
    @(negedge clk);
    bus.we = 1'b0;
    rd1("r0_p1", 5'd0, 32'h0);
    rd2("r0_p2", 5'd0, 32'h0);
    bus.re1 = 1'b0; bus.re2 = 1'b0;
    @(negedge clk);

    // Load r1..r31 with i*0x01010101
    for (int i = 1; i < REG_NUM; i++) wr(ADDR_W'(i), 32'(i) * 32'h0101_0101);
    rd1("load_r17", 5'd17, 32'h1111_1111);
    rd2("load_r31", 5'd31, 32'h1F1F_1F1F);
    bus.re1 = 1'b0; bus.re2 = 1'b0;
    @(negedge clk);

    // Back-to-back dump
    do_dump(1'b0, -1, -1, -1);

    // Stalling dump: write r10 while beat 10 stalls, bypass-load r21
    do_dump(1'b1, 10, 21, -1);
    rd1("r10_after_dump", 5'd10, 32'h0000_0055);
    rd2("r21_after_dump", 5'd21, 32'hCAFE_F00D);
    bus.re1 = 1'b0; bus.re2 = 1'b0;
    @(negedge clk);

    // Reset at idx 15 aborts; a new dump restarts from idx 0 with cleared regs
    do_dump(1'b0, -1, -1, 15);
    do_dump(1'b0, -1, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute watchdog so the bench always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
